mips_cpu_muldiv_seq: RTL

MIPS_CPU_MULDIV_SEQ -- requirements
Module: mips_cpu_muldiv_seq

---
 rtl/mips_cpu_pkg.sv | 24 ++
 rtl/mips_cpu_div_core.sv | 54 +++++
 rtl/mips_cpu_muldiv_seq.sv | 112 +++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the MIPS multiply/divide unit:
// HI/LO operation select, sequencer states, operand magnitude helper.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v,
                                          input logic        sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_cpu_div_core.sv
// Iterative restoring unsigned divider, one quotient bit per clock.
// start loads the operands; done flags the edge that retires the last bit.
import mips_cpu_pkg::*;

module mips_cpu_div_core (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;
    logic        run_q;
    logic [32:0] trial;
    logic [32:0] diff;

    // Shift the next dividend bit into the partial remainder, then trial-subtract.
    assign trial = {rem_q, quo_q[31]};
    assign diff  = trial - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= diff[32] ? trial[31:0] : diff[31:0];
            quo_q <= {quo_q[30:0], ~diff[32]};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31)
                run_q <= 1'b0;
        end
    end

    assign done      = run_q && (cnt_q == 5'd31);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mips_cpu_muldiv_seq.sv
// MIPS HI/LO multiply/divide sequencer: single-cycle multiply,
// 32-step divide through mips_cpu_div_core, sign fix-up, MTHI/MTLO.
import mips_cpu_pkg::*;

module mips_cpu_muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    state_t      state;
    op_t         op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        div_start;
    logic        div_done;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        sx;
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] prod;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    assign busy      = (state != S_IDLE);
    assign div_start = (state == S_IDLE) && start && op[1];

    mips_cpu_div_core u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (mag32(A, op == OP_DIV)),
        .divisor   (mag32(B, op == OP_DIV)),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    assign sx   = (op_q == OP_MULT);
    assign ax   = {{32{sx & a_q[31]}}, a_q};
    assign bx   = {{32{sx & b_q[31]}}, b_q};
    assign prod = ax * bx;

    // Remainder follows the dividend sign; quotient negates on sign mismatch.
    assign neg_q = (op_q == OP_DIV) && (a_q[31] ^ b_q[31]);
    assign neg_r = (op_q == OP_DIV) && a_q[31];
    assign q_fix = neg_q ? (~quo + 32'd1) : quo;
    assign r_fix = neg_r ? (~rem + 32'd1) : rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= op_t'(op);
                        state <= op[1] ? S_DIV : S_MUL;
                    end else begin
                        if (mthi)
                            hi <= wdata;
                        if (mtlo)
                            lo <= wdata;
                    end
                end
                S_MUL: begin
                    {hi, lo} <= prod;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                S_DIV: begin
                    if (div_done)
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (b_q == 32'd0) begin
                        hi <= a_q;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
